// File: rtl/shift_tx_sequencer.sv
// Valid/ready word loader that shifts a word out MSB-first, DIV clocks per bit.
// Optional trailing even-parity bit is compiled in with `define SEQ_PARITY_EN.
module shift_tx_sequencer #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              hold,
  output logic              shift_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tx_count
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SEQ_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              bit_end;
`ifdef SEQ_PARITY_EN
  logic              parity_bit;
`endif

  assign bit_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output and state_nxt gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    shift_out  = 1'b0;
    bit_strobe = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !hold;
        if (in_valid && !hold) state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_out  = sreg[DATA_W-1];
        bit_strobe = (div_cnt == '0) && !hold;
        if (!hold && bit_end && (bit_cnt == BIT_LAST)) begin
`ifdef SEQ_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SEQ_PARITY_EN
      PARITY: begin
        shift_out  = parity_bit;
        bit_strobe = (div_cnt == '0) && !hold;
        if (!hold && bit_end) state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: hold freezes everything in SHIFT/PARITY; DONE never stalls.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_count <= '0;
`ifdef SEQ_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !hold) begin
            sreg    <= in_data;
            div_cnt <= '0;
            bit_cnt <= '0;
`ifdef SEQ_PARITY_EN
            parity_bit <= ^in_data;
`endif
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (bit_end) begin
              div_cnt <= '0;
              sreg    <= {sreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
`ifdef SEQ_PARITY_EN
        PARITY: begin
          if (!hold) div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
        end
`endif
        DONE: tx_count <= tx_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Scoreboard bench for shift_tx_sequencer: a per-cycle expected-output queue is
// filled from a behavioural model as stimulus is driven and drained at negedge.
module tb_shift_tx_sequencer;

`ifdef SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int DIV = 4;

  logic        clk, rst;
  logic        in_valid, hold, in_ready, shift_out, bit_strobe, busy, done;
  logic [7:0]  in_data;
  logic [15:0] tx_count;

  logic        in_valid_b, hold_b, in_ready_b, shift_out_b, bit_strobe_b, busy_b, done_b;
  logic [7:0]  in_data_b;
  logic [3:0]  tx_count_b;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = '0;

  typedef struct {
    int          cyc;
    logic        so, strobe, bsy, dn, rdy;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  shift_tx_sequencer #(.DATA_W(8), .DIV(DIV), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .hold(hold), .shift_out(shift_out),
    .bit_strobe(bit_strobe), .busy(busy), .done(done), .tx_count(tx_count)
  );

  // Narrow counter on the DIV=1 instance makes the wrap reachable in few sends.
  shift_tx_sequencer #(.DATA_W(8), .DIV(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .hold(hold_b), .shift_out(shift_out_b),
    .bit_strobe(bit_strobe_b), .busy(busy_b), .done(done_b), .tx_count(tx_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sends one word and checks every cycle through the following IDLE cycle.
  // skip_start: cycle 0 was already driven by a chained previous call.
  task automatic run_word(input string tag, input logic [7:0] data, input bit skip_start,
                          input int hold_start, input int hold_len,
                          input bit chain, input logic [7:0] next_data);
    int   p = 0;
    int   total = (8 + PAR) * DIV;
    bit   last = 0;
    logic hc;
    exp_t e;
    if (!skip_start) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = data; hold = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s start_ready got=%b exp=1", tag, in_ready);
      end
    end
    for (int c = 1; c < 200 && !last; c++) begin
      hc = (c >= hold_start) && (c < hold_start + hold_len);
      @(posedge clk); #1;
      hold = hc;
      if (chain) begin in_valid = 1'b1; in_data = 8'($urandom); end
      else in_valid = 1'b0;
      e.cyc = c;
      if (p < total) begin
        e.so     = (p / DIV < 8) ? data[7 - p / DIV] : ^data;
        e.strobe = (p % DIV == 0) && !hc;
        e.bsy = 1'b1; e.dn = 1'b0; e.rdy = 1'b0; e.cnt = exp_count;
        if (!hc) p++;
      end else if (p == total) begin
        e.so = 1'b0; e.strobe = 1'b0; e.bsy = 1'b1; e.dn = 1'b1; e.rdy = 1'b0;
        e.cnt = exp_count;
        exp_count = exp_count + 16'd1;
        p++;
      end else begin
        e.so = 1'b0; e.strobe = 1'b0; e.bsy = 1'b0; e.dn = 1'b0; e.rdy = !hc;
        e.cnt = exp_count;
        if (chain) in_data = next_data;
        last = 1;
      end
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (shift_out !== e.so) begin
        failures++;
        $display("FAIL %s shift_out cyc=%0d got=%b exp=%b", tag, e.cyc, shift_out, e.so);
      end
      checks++;
      if (bit_strobe !== e.strobe) begin
        failures++;
        $display("FAIL %s bit_strobe cyc=%0d got=%b exp=%b", tag, e.cyc, bit_strobe, e.strobe);
      end
      checks++;
      if (busy !== e.bsy) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, e.cyc, busy, e.bsy);
      end
      checks++;
      if (done !== e.dn) begin
        failures++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, e.cyc, done, e.dn);
      end
      checks++;
      if (in_ready !== e.rdy) begin
        failures++;
        $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", tag, e.cyc, in_ready, e.rdy);
      end
      checks++;
      if (tx_count !== e.cnt) begin
        failures++;
        $display("FAIL %s tx_count cyc=%0d got=%h exp=%h", tag, e.cyc, tx_count, e.cnt);
      end
    end
    checks++;
    if (!last) begin
      failures++;
      $display("FAIL %s timeout waiting for IDLE", tag);
    end
    hold = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst busy got=%b exp=0", busy); end
    checks++; if (shift_out !== 1'b0) begin failures++; $display("FAIL rst shift_out got=%b exp=0", shift_out); end
    checks++; if (bit_strobe !== 1'b0) begin failures++; $display("FAIL rst bit_strobe got=%b exp=0", bit_strobe); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst done got=%b exp=0", done); end
    checks++; if (tx_count !== 16'h0) begin failures++; $display("FAIL rst tx_count got=%h exp=0000", tx_count); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_send_a5;
    run_word("a5", 8'hA5, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_parity;
    run_word("par07", 8'h07, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_hold_mid_bit;
    run_word("hold3c", 8'h3C, 0, 14, 5, 0, 8'h00);
  endtask

  task automatic test_hold_idle;
    bit bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 hold = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      @(negedge clk);
      if (in_ready !== 1'b0) bad = 1;
    end
    @(posedge clk); #1 hold = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bad || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle ready_seen=%b busy=%b exp ready=0 busy=0", bad, busy);
    end
  endtask

  task automatic test_back_to_back;
    run_word("b2b01", 8'h01, 0, 0, 0, 1, 8'h80);
    run_word("b2b80", 8'h80, 1, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset_mid_word;
    bit seen = 0;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hFF;
    repeat (10) begin @(posedge clk); #1 in_valid = 1'b0; end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst busy_before got=%b exp=1", busy); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_count = '0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst busy got=%b exp=0", busy); end
    checks++; if (tx_count !== 16'h0) begin failures++; $display("FAIL midrst tx_count got=%h exp=0000", tx_count); end
    checks++; if (shift_out !== 1'b0) begin failures++; $display("FAIL midrst shift_out got=%b exp=0", shift_out); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midrst done_or_busy got=1 exp=0"); end
  endtask

  task automatic test_wrap_div1;
    logic [7:0] w = 8'h55;
    bit got;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1 in_valid_b = 1'b1; in_data_b = 8'(i);
      @(posedge clk); #1 in_valid_b = 1'b0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        if (done_b) got = 1;
      end
      checks++;
      if (!got) begin failures++; $display("FAIL wrap preload word=%0d timeout", i); end
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (tx_count_b !== 4'hF) begin failures++; $display("FAIL wrap preload tx_count got=%h exp=f", tx_count_b); end
    @(posedge clk); #1 in_valid_b = 1'b1; in_data_b = w;
    @(posedge clk); #1 in_valid_b = 1'b0; in_data_b = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bit_strobe_b !== 1'b1) begin failures++; $display("FAIL div1 strobe bit=%0d got=%b exp=1", k, bit_strobe_b); end
      checks++;
      if (shift_out_b !== w[7-k]) begin failures++; $display("FAIL div1 shift_out bit=%0d got=%b exp=%b", k, shift_out_b, w[7-k]); end
    end
    if (PAR == 1) begin
      @(negedge clk);
      checks++;
      if (shift_out_b !== ^w) begin failures++; $display("FAIL div1 parity got=%b exp=%b", shift_out_b, ^w); end
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b1) begin failures++; $display("FAIL div1 done got=%b exp=1", done_b); end
    @(negedge clk);
    checks++;
    if (tx_count_b !== 4'h0) begin failures++; $display("FAIL wrap tx_count got=%h exp=0", tx_count_b); end
    checks++;
    if (in_ready_b !== 1'b1) begin failures++; $display("FAIL div1 in_ready got=%b exp=1", in_ready_b); end
  endtask

  initial begin
    test_reset;
    test_send_a5;
`ifdef SEQ_PARITY_EN
    test_parity;
`endif
    test_hold_mid_bit;
    test_hold_idle;
    test_back_to_back;
    test_reset_mid_word;
    test_wrap_div1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
